mp_host_seq: RTL
================

Name: mp_host_seq

Overview:
- Bus-master sequencer placed directly upstream of the mp processing block; it is the only driver of mp's slave port (wr, sel, addr, din) and the only consumer of its s_dout and interrupt_out.
- Accepts high-level commands from the system over a valid/ready stream: load operand, load instruction, run, read result.
- Converts each command into mp slave-bus cycles and returns run status and read data on a valid/ready response stream.

Parameters:
- TIMEOUT, default 4096: maximum cycles WAIT_IRQ waits for interrupt before aborting a run.
- RD_LAT, default 1: cycles from read-address issue to valid m_din.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_type  in  2  0=load operand, 1=load instruction, 2=run, 3=read result.
- cmd_idx  in  4  register/instruction slot index.
- cmd_data  in  32  operand value, or instruction in bits [15:0].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  64  read data, or run status.
- m_wr  out  1  mp write strobe (1=write, 0=read).
- m_sel  out  1  mp select.
- m_addr  out  16  mp address.
- m_dout  out  32  mp write data.
- m_din  in  64  mp read data.
- irq_in  in  1  mp interrupt_out.

Behaviour:
- Address map:
  - operand/result register i at 0x0100+i.
  - instruction slot j at 0x0110+j; instruction bits [31:16] are written as 0.
  - control at 0x0120: write 1 = start, write 0 = clear start/interrupt.
- Reset (reset_n=0 at a clock edge):
  - Outputs: cmd_ready=0, rsp_valid=0, rsp_data=0, m_sel=0, m_wr=0, m_addr=0, m_dout=0.
  - Internal: state=IDLE, cycle counter=0.
  - Applies in any state, including mid-run; an in-flight command is dropped with no response.
- A command is accepted when cmd_valid & cmd_ready are both 1 at an edge. cmd_ready=1 only in IDLE.
- States and transitions:
  - IDLE: cmd_ready=1, m_sel=0. On accept, capture cmd_* and go to WR (types 0, 1), START (type 2) or RD (type 3).
  - WR: one cycle with m_sel=1, m_wr=1, m_addr, m_dout driven. Next state IDLE; no response is generated.
  - START: one cycle writing 1 to 0x0120; clear the counter. Next WAIT_IRQ.
  - WAIT_IRQ: m_sel=0; counter increments each cycle.
    - irq_in=1: go to CLR with status=OK.
    - Counter reaches TIMEOUT-1 with irq_in still 0: go to CLR with status=TIMEOUT.
    - irq_in=1 in the same cycle the counter reaches TIMEOUT-1: status=OK.
  - CLR: one cycle writing 0 to 0x0120. Next RSP with rsp_data[63]=timeout flag and rsp_data[31:0]=cycles waited (counter value at exit).
  - RD: m_sel=1, m_wr=0, m_addr=0x0100+idx, held for RD_LAT cycles; then capture m_din into rsp_data and go to RSP.
  - RSP: rsp_valid=1 with rsp_data stable until rsp_ready=1, then go to IDLE. rsp_valid deasserts in the cycle after the handshake.
- m_* outputs are registered. m_sel is 0 in every state not listed as driving it.
- Back-to-back commands: minimum 2 cycles per load (accept + WR). The next accept occurs in the cycle after WR.
- irq_in asserted outside WAIT_IRQ is ignored.
- cmd_idx is 4 bits and addresses wrap within each 16-entry window; no out-of-range check is needed.
- Run status counter is 32 bits, saturating; it cannot overflow for TIMEOUT < 2^32.

Test Plan:
- Reset hold: assert reset_n=0 for 3 cycles mid-WAIT_IRQ -> all outputs 0, state IDLE, cmd_ready=1 on the first cycle after release, no rsp_valid.
- Load path: type0 idx1 data 7, then type0 idx2 data 0xFFFF_FFF9, then type1 idx0 data 0x0312 -> bus sees writes (0x0101, 7), (0x0102, 0xFFFFFFF9), (0x0110, 0x0312) on consecutive WR cycles, exactly 2 cycles apart.
- Run OK: type2 with irq_in raised 20 cycles after start -> write (0x0120, 1), then write (0x0120, 0), then rsp_data[63]=0 and rsp_data[31:0]=20.
- Run timeout: TIMEOUT=16, irq_in held 0 -> clear write issued, rsp_data[63]=1, rsp_data[31:0]=15. Also drive irq_in=1 exactly at count 15 -> status OK.
- Read with backpressure: type3 idx3, m_din=0x0000_0000_FFFF_FFF9 -> read of 0x0103; hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stay stable, and cmd_ready stays 0 until the handshake.
- Stray interrupt: pulse irq_in during IDLE and WR -> no state change, no extra bus cycles.

Source files
------------

// File: rtl/mp_host_seq.sv
// Command-stream to mp slave-bus sequencer: turns load/run/read commands into
// registered bus cycles and reports run status or read data on a response stream.
module mp_host_seq #(
  parameter int TIMEOUT = 4096,
  parameter int RD_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [3:0]  cmd_idx,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        m_wr,
  output logic        m_sel,
  output logic [15:0] m_addr,
  output logic [31:0] m_dout,
  input  logic [63:0] m_din,
  input  logic        irq_in
);

  localparam logic [31:0] CNT_LAST  = 32'(TIMEOUT - 1);
  localparam logic [15:0] LAT_LAST  = 16'(RD_LAT - 1);
  localparam logic [15:0] CTRL_ADDR = 16'h0120;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    START,
    WAIT_IRQ,
    CLR,
    RD,
    RSP
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] cnt_nxt;
  logic [15:0] lat;
  logic        tflag;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign cnt_nxt = sat_inc(cnt);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat       <= '0;
      tflag     <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      m_sel     <= 1'b0;
      m_wr      <= 1'b0;
      m_addr    <= '0;
      m_dout    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          m_sel     <= 1'b0;
          m_wr      <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            // Bus cycle is set up on the accept edge so it appears in the next state.
            case (cmd_type)
              2'd0: begin
                m_sel  <= 1'b1;
                m_wr   <= 1'b1;
                m_addr <= {12'h010, cmd_idx};
                m_dout <= cmd_data;
                state  <= WR;
              end
              2'd1: begin
                m_sel  <= 1'b1;
                m_wr   <= 1'b1;
                m_addr <= {12'h011, cmd_idx};
                m_dout <= {16'h0000, cmd_data[15:0]};
                state  <= WR;
              end
              2'd2: begin
                m_sel  <= 1'b1;
                m_wr   <= 1'b1;
                m_addr <= CTRL_ADDR;
                m_dout <= 32'd1;
                cnt    <= '0;
                state  <= START;
              end
              default: begin
                m_sel  <= 1'b1;
                m_wr   <= 1'b0;
                m_addr <= {12'h010, cmd_idx};
                lat    <= '0;
                state  <= RD;
              end
            endcase
          end
        end
        WR: begin
          m_sel     <= 1'b0;
          m_wr      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        START: begin
          m_sel <= 1'b0;
          m_wr  <= 1'b0;
          cnt   <= '0;
          state <= WAIT_IRQ;
        end
        WAIT_IRQ: begin
          cnt <= cnt_nxt;
          // An interrupt on the final counted cycle still wins over the timeout.
          if (irq_in || (cnt_nxt >= CNT_LAST)) begin
            tflag  <= ~irq_in;
            m_sel  <= 1'b1;
            m_wr   <= 1'b1;
            m_addr <= CTRL_ADDR;
            m_dout <= 32'd0;
            state  <= CLR;
          end
        end
        CLR: begin
          m_sel     <= 1'b0;
          m_wr      <= 1'b0;
          rsp_data  <= {tflag, 31'd0, cnt};
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RD: begin
          if (lat == LAT_LAST) begin
            m_sel     <= 1'b0;
            rsp_data  <= m_din;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end else begin
            lat <= lat + 16'd1;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          m_sel     <= 1'b0;
          m_wr      <= 1'b0;
          cmd_ready <= 1'b0;
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
